// File: rtl/genesys_pkg.sv
// Shared definitions for the genesys iterator blocks: table sizing defaults,
// iterator table FSM encoding and the depth derivation used by every table.
package genesys_pkg;

    // Defaults shared with the iterator address generator.
    localparam int ITER_NS_INDEX_ID_BITS  = 5;
    localparam int ITER_BASE_STRIDE_WIDTH = 32;

    typedef enum logic {
        ITER_INIT = 1'b0,
        ITER_RUN  = 1'b1
    } iter_state_e;

    function automatic int iter_table_depth(input int index_bits);
        return 1 << index_bits;
    endfunction

endpackage

// File: rtl/iterator_regfile.sv
// One-write, one-read table with a registered, write-first read port.
// The read register only updates on re, so it holds the last read otherwise.
module iterator_regfile
    import genesys_pkg::*;
#(
    parameter int ADDR_BITS  = ITER_NS_INDEX_ID_BITS,
    parameter int DATA_WIDTH = ITER_BASE_STRIDE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = iter_table_depth(ADDR_BITS);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    // Array write kept in its own process so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/iterator_table.sv
// Per-namespace iterator base/stride table: clears itself after reset, then
// serves one-cycle reads with write-first forwarding and an optional base bypass.
module iterator_table
    import genesys_pkg::*;
#(
    parameter int NS_INDEX_ID_BITS  = ITER_NS_INDEX_ID_BITS,
    parameter int BASE_STRIDE_WIDTH = ITER_BASE_STRIDE_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         read_req,
    input  logic [NS_INDEX_ID_BITS-1:0]  read_addr,
    input  logic                         write_req_base,
    input  logic [NS_INDEX_ID_BITS-1:0]  write_addr_base,
    input  logic [BASE_STRIDE_WIDTH-1:0] data_in_base,
    input  logic                         write_req_stride,
    input  logic [NS_INDEX_ID_BITS-1:0]  write_addr_stride,
    input  logic [BASE_STRIDE_WIDTH-1:0] data_in_stride,
    input  logic                         mem_bypass,
    input  logic [BASE_STRIDE_WIDTH-1:0] base_plus_stride,
    output logic [BASE_STRIDE_WIDTH-1:0] iterator_base,
    output logic [BASE_STRIDE_WIDTH-1:0] iterator_stride,
    output logic                         read_valid,
    output logic                         init_done
);

    localparam int DEPTH = iter_table_depth(NS_INDEX_ID_BITS);
    localparam logic [NS_INDEX_ID_BITS-1:0] LAST_IDX = NS_INDEX_ID_BITS'(DEPTH - 1);
    localparam int NUM_RF = 2;  // index 0 = base, index 1 = stride

    iter_state_e                  state_reg, state_next;
    logic [NS_INDEX_ID_BITS-1:0]  init_cnt_reg, init_cnt_next;
    logic                         run;

    logic                         wr_en   [NUM_RF];
    logic [NS_INDEX_ID_BITS-1:0]  wr_addr [NUM_RF];
    logic [BASE_STRIDE_WIDTH-1:0] wr_data [NUM_RF];
    logic [BASE_STRIDE_WIDTH-1:0] rd_data [NUM_RF];
    logic                         rd_en;

    logic                         read_valid_reg;
    logic                         bypass_sel_reg;
    logic [BASE_STRIDE_WIDTH-1:0] bypass_data_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ITER_INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        case (state_reg)
            ITER_INIT: begin
                init_cnt_next = init_cnt_reg + 1'b1;
                if (init_cnt_reg == LAST_IDX) begin
                    state_next = ITER_RUN;
                end
            end
            ITER_RUN: begin
                state_next = ITER_RUN;
            end
            default: begin
                state_next = ITER_INIT;
            end
        endcase
    end

    assign run = (state_reg == ITER_RUN);

    // The sweep owns both write ports during INIT; user writes only in RUN.
    // Gating with reset keeps a reset cycle from committing anything.
    always_comb begin
        for (int i = 0; i < NUM_RF; i++) begin
            wr_en[i]   = 1'b0;
            wr_addr[i] = init_cnt_reg;
            wr_data[i] = '0;
        end
        if (!run) begin
            wr_en[0] = reset;
            wr_en[1] = reset;
        end else begin
            wr_en[0]   = reset && write_req_base;
            wr_addr[0] = write_addr_base;
            wr_data[0] = data_in_base;
            wr_en[1]   = reset && write_req_stride;
            wr_addr[1] = write_addr_stride;
            wr_data[1] = data_in_stride;
        end
    end

    assign rd_en = reset && run && read_req;

    generate
        for (genvar gi = 0; gi < NUM_RF; gi++) begin : g_rf
            iterator_regfile #(
                .ADDR_BITS  (NS_INDEX_ID_BITS),
                .DATA_WIDTH (BASE_STRIDE_WIDTH)
            ) u_rf (
                .clk   (clk),
                .reset (reset),
                .we    (wr_en[gi]),
                .waddr (wr_addr[gi]),
                .wdata (wr_data[gi]),
                .re    (rd_en),
                .raddr (read_addr),
                .rdata (rd_data[gi])
            );
        end
    endgenerate

    // Bypass select/data are captured with the read so they hold alongside it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            read_valid_reg  <= 1'b0;
            bypass_sel_reg  <= 1'b0;
            bypass_data_reg <= '0;
        end else begin
            read_valid_reg <= rd_en;
            if (rd_en) begin
                bypass_sel_reg  <= mem_bypass;
                bypass_data_reg <= base_plus_stride;
            end
        end
    end

    assign iterator_base   = bypass_sel_reg ? bypass_data_reg : rd_data[0];
    assign iterator_stride = rd_data[1];
    assign read_valid      = read_valid_reg;
    assign init_done       = run;

endmodule

// File: tb/tb_iterator_table.sv
// Scoreboard bench for iterator_table: expected reads are queued when issued
// and compared when read_valid returns.
module tb_iterator_table;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          read_req;
    logic [AW-1:0] read_addr;
    logic          write_req_base;
    logic [AW-1:0] write_addr_base;
    logic [DW-1:0] data_in_base;
    logic          write_req_stride;
    logic [AW-1:0] write_addr_stride;
    logic [DW-1:0] data_in_stride;
    logic          mem_bypass;
    logic [DW-1:0] base_plus_stride;
    logic [DW-1:0] iterator_base;
    logic [DW-1:0] iterator_stride;
    logic          read_valid;
    logic          init_done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]     base_m   [DEPTH];
    logic [DW-1:0]     stride_m [DEPTH];
    logic [2*DW-1:0]   sb [$];

    iterator_table #(
        .NS_INDEX_ID_BITS  (AW),
        .BASE_STRIDE_WIDTH (DW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .read_req          (read_req),
        .read_addr         (read_addr),
        .write_req_base    (write_req_base),
        .write_addr_base   (write_addr_base),
        .data_in_base      (data_in_base),
        .write_req_stride  (write_req_stride),
        .write_addr_stride (write_addr_stride),
        .data_in_stride    (data_in_stride),
        .mem_bypass        (mem_bypass),
        .base_plus_stride  (base_plus_stride),
        .iterator_base     (iterator_base),
        .iterator_stride   (iterator_stride),
        .read_valid        (read_valid),
        .init_done         (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        read_req          = 1'b0;
        read_addr         = '0;
        write_req_base    = 1'b0;
        write_addr_base   = '0;
        data_in_base      = '0;
        write_req_stride  = 1'b0;
        write_addr_stride = '0;
        data_in_stride    = '0;
        mem_bypass        = 1'b0;
        base_plus_stride  = '0;
    endtask

    // Releases reset and runs the sweep while hammering base[5] and reads,
    // which must all be ignored. Returns cycles until init_done.
    task automatic sweep_after_reset(output int cyc, output int rv_seen);
        reset           = 1'b1;
        write_req_base  = 1'b1;
        write_addr_base = 5'd5;
        data_in_base    = 32'h55;
        read_req        = 1'b1;
        read_addr       = 5'd5;
        cyc     = 0;
        rv_seen = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (read_valid) rv_seen++;
            if (init_done) break;
        end
        clear_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            base_m[i]   = '0;
            stride_m[i] = '0;
        end
    endtask

    task automatic test_reset();
        int cyc, rv;
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b exp 0", init_done); end
        checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL reset_read_valid got %b exp 0", read_valid); end
        checks++; if (iterator_base !== '0) begin errors++; $display("FAIL reset_base got %h exp 0", iterator_base); end
        checks++; if (iterator_stride !== '0) begin errors++; $display("FAIL reset_stride got %h exp 0", iterator_stride); end
        sweep_after_reset(cyc, rv);
        checks++; if (cyc != 32) begin errors++; $display("FAIL init_latency got %0d exp 32", cyc); end
        checks++; if (rv != 0) begin errors++; $display("FAIL init_read_valid pulses got %0d exp 0", rv); end
        $display("reset: init_done after %0d cycles", cyc);
    endtask

    task automatic test_read_all(input string name);
        logic [2*DW-1:0] exp;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i > 0) begin
                checks++;
                if (read_valid !== 1'b1) begin errors++; $display("FAIL %s_rv[%0d] got %b exp 1", name, i - 1, read_valid); end
                exp = (sb.size() > 0) ? sb.pop_front() : '0;
                checks++;
                if ({iterator_base, iterator_stride} !== exp)
                    begin errors++; $display("FAIL %s_data[%0d] got %h/%h exp %h/%h", name, i - 1, iterator_base, iterator_stride, exp[2*DW-1:DW], exp[DW-1:0]); end
            end
            if (i < DEPTH) begin
                read_req  = 1'b1;
                read_addr = AW'(i);
                sb.push_back({base_m[i], stride_m[i]});
            end else begin
                read_req = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL %s_rv_tail got %b exp 0", name, read_valid); end
        $display("%s: read %0d entries", name, DEPTH);
    endtask

    task automatic test_write_read();
        logic [2*DW-1:0] exp;
        write_req_base    = 1'b1; write_addr_base   = 5'd3; data_in_base   = 32'h0000_1234;
        write_req_stride  = 1'b1; write_addr_stride = 5'd3; data_in_stride = 32'hFFFF_FFFC;
        base_m[3] = 32'h0000_1234; stride_m[3] = 32'hFFFF_FFFC;
        @(negedge clk);
        write_req_base = 1'b0; write_req_stride = 1'b0;
        read_req = 1'b1; read_addr = 5'd3;
        sb.push_back({base_m[3], stride_m[3]});
        @(negedge clk);
        read_req = 1'b0;
        checks++; if (read_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_rv got %b exp 1", read_valid); end
        exp = sb.pop_front();
        checks++; if ({iterator_base, iterator_stride} !== exp)
            begin errors++; $display("FAIL wr_rd_data got %h/%h exp %h/%h", iterator_base, iterator_stride, exp[2*DW-1:DW], exp[DW-1:0]); end
        @(negedge clk);
        checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL hold_rv got %b exp 0", read_valid); end
        checks++; if ({iterator_base, iterator_stride} !== {32'h0000_1234, 32'hFFFF_FFFC})
            begin errors++; $display("FAIL hold_data got %h/%h exp 00001234/fffffffc", iterator_base, iterator_stride); end
        $display("write_read: base=%h stride=%h", iterator_base, iterator_stride);
    endtask

    task automatic test_write_first();
        logic [2*DW-1:0] exp;
        write_req_base = 1'b1; write_addr_base = 5'd7; data_in_base = 32'hA5A5_A5A5;
        read_req = 1'b1; read_addr = 5'd7;
        base_m[7] = 32'hA5A5_A5A5;
        sb.push_back({base_m[7], stride_m[7]});
        @(negedge clk);
        checks++; if (read_valid !== 1'b1) begin errors++; $display("FAIL wf_base_rv got %b exp 1", read_valid); end
        exp = sb.pop_front();
        checks++; if ({iterator_base, iterator_stride} !== exp)
            begin errors++; $display("FAIL wf_base_data got %h/%h exp %h/%h", iterator_base, iterator_stride, exp[2*DW-1:DW], exp[DW-1:0]); end
        // Independent indices on the two ports; forwarding only on the stride side.
        write_addr_base = 5'd2; data_in_base = 32'h2222_0002;
        write_req_stride = 1'b1; write_addr_stride = 5'd9; data_in_stride = 32'h0BAD_F00D;
        read_addr = 5'd9;
        base_m[2] = 32'h2222_0002; stride_m[9] = 32'h0BAD_F00D;
        sb.push_back({base_m[9], stride_m[9]});
        @(negedge clk);
        checks++; if (read_valid !== 1'b1) begin errors++; $display("FAIL wf_stride_rv got %b exp 1", read_valid); end
        exp = sb.pop_front();
        checks++; if ({iterator_base, iterator_stride} !== exp)
            begin errors++; $display("FAIL wf_stride_data got %h/%h exp %h/%h", iterator_base, iterator_stride, exp[2*DW-1:DW], exp[DW-1:0]); end
        clear_inputs();
        read_req = 1'b1; read_addr = 5'd2;
        sb.push_back({base_m[2], stride_m[2]});
        @(negedge clk);
        read_req = 1'b0;
        exp = sb.pop_front();
        checks++; if ({read_valid, iterator_base, iterator_stride} !== {1'b1, exp})
            begin errors++; $display("FAIL wf_indep_data got %b %h/%h exp 1 %h/%h", read_valid, iterator_base, iterator_stride, exp[2*DW-1:DW], exp[DW-1:0]); end
        $display("write_first: base[7]=%h stride[9]=%h", base_m[7], stride_m[9]);
    endtask

    task automatic test_bypass();
        logic [2*DW-1:0] exp;
        read_req = 1'b1; read_addr = 5'd3; mem_bypass = 1'b1; base_plus_stride = 32'h0000_1230;
        sb.push_back({32'h0000_1230, stride_m[3]});
        @(negedge clk);
        exp = sb.pop_front();
        checks++; if ({read_valid, iterator_base, iterator_stride} !== {1'b1, exp})
            begin errors++; $display("FAIL bypass_data got %b %h/%h exp 1 %h/%h", read_valid, iterator_base, iterator_stride, exp[2*DW-1:DW], exp[DW-1:0]); end
        mem_bypass = 1'b0;
        sb.push_back({base_m[3], stride_m[3]});
        @(negedge clk);
        exp = sb.pop_front();
        checks++; if ({read_valid, iterator_base, iterator_stride} !== {1'b1, exp})
            begin errors++; $display("FAIL bypass_entry_unchanged got %b %h/%h exp 1 %h/%h", read_valid, iterator_base, iterator_stride, exp[2*DW-1:DW], exp[DW-1:0]); end
        read_req = 1'b0; mem_bypass = 1'b1; base_plus_stride = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if ({read_valid, iterator_base, iterator_stride} !== {1'b0, base_m[3], stride_m[3]})
            begin errors++; $display("FAIL bypass_no_read got %b %h/%h exp 0 %h/%h", read_valid, iterator_base, iterator_stride, base_m[3], stride_m[3]); end
        clear_inputs();
        $display("bypass: base=%h stride=%h", iterator_base, iterator_stride);
    endtask

    task automatic test_back_to_back();
        logic [2*DW-1:0] exp;
        logic            exp_valid = 1'b0;
        int              reads = 0;
        for (int c = 0; c <= 300; c++) begin
            if (exp_valid) begin
                checks++;
                if (read_valid !== 1'b1) begin errors++; $display("FAIL b2b_rv cycle %0d got %b exp 1", c, read_valid); end
                exp = (sb.size() > 0) ? sb.pop_front() : '0;
                checks++;
                if ({iterator_base, iterator_stride} !== exp)
                    begin errors++; $display("FAIL b2b_data cycle %0d got %h/%h exp %h/%h", c, iterator_base, iterator_stride, exp[2*DW-1:DW], exp[DW-1:0]); end
            end else begin
                checks++;
                if (read_valid !== 1'b0) begin errors++; $display("FAIL b2b_rv cycle %0d got %b exp 0", c, read_valid); end
            end
            if (c == 300) begin
                clear_inputs();
                exp_valid = 1'b0;
            end else begin
                write_req_base    = 1'($urandom_range(0, 1));
                write_addr_base   = AW'($urandom_range(0, 7));
                data_in_base      = $urandom;
                write_req_stride  = 1'($urandom_range(0, 1));
                write_addr_stride = AW'($urandom_range(0, 7));
                data_in_stride    = $urandom;
                read_req          = 1'($urandom_range(0, 2) != 0);
                read_addr         = AW'($urandom_range(0, 7));
                mem_bypass        = 1'($urandom_range(0, 3) == 0);
                base_plus_stride  = $urandom;
                if (write_req_base)   base_m[write_addr_base]     = data_in_base;
                if (write_req_stride) stride_m[write_addr_stride] = data_in_stride;
                if (read_req) begin
                    reads++;
                    sb.push_back({mem_bypass ? base_plus_stride : base_m[read_addr], stride_m[read_addr]});
                end
                exp_valid = read_req;
                @(negedge clk);
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_scoreboard_left got %0d exp 0", sb.size()); end
        $display("back_to_back: %0d reads", reads);
    endtask

    task automatic test_reset_midrun();
        int cyc, rv;
        for (int i = 0; i < 10; i++) begin
            write_req_base   = 1'b1; write_addr_base   = AW'(i + 10); data_in_base   = 32'h1000 + i;
            write_req_stride = 1'b1; write_addr_stride = AW'(i + 20); data_in_stride = 32'h2000 + i;
            read_req = 1'b0;
            @(negedge clk);
        end
        // Writes held high across the reset cycle must not land.
        reset = 1'b0;
        write_addr_base = 5'd31; data_in_base = 32'hFFFF_FFFF;
        read_req = 1'b1; read_addr = 5'd3;
        @(negedge clk);
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL midrun_init_done got %b exp 0", init_done); end
        checks++; if ({read_valid, iterator_base, iterator_stride} !== {1'b0, 64'h0})
            begin errors++; $display("FAIL midrun_outputs got %b %h/%h exp 0 0/0", read_valid, iterator_base, iterator_stride); end
        sweep_after_reset(cyc, rv);
        checks++; if (cyc != 32) begin errors++; $display("FAIL midrun_latency got %0d exp 32", cyc); end
        checks++; if (rv != 0) begin errors++; $display("FAIL midrun_read_valid pulses got %0d exp 0", rv); end
        $display("reset_midrun: init_done after %0d cycles", cyc);
    endtask

    initial begin
        test_reset();
        test_read_all("clear");
        test_write_read();
        test_write_first();
        test_bypass();
        test_back_to_back();
        test_reset_midrun();
        test_read_all("reclear");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iterator_table.md
ITERATOR_TABLE -- requirements
Module: iterator_table

Interface
REQ-001 Parameter NS_INDEX_ID_BITS, default 5: entry address width; table depth DEPTH = 2**NS_INDEX_ID_BITS.
REQ-002 Parameter BASE_STRIDE_WIDTH, default 32: base and stride word width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 read_req  in  1  read base and stride at read_addr.
REQ-006 read_addr  in  NS_INDEX_ID_BITS  read entry index.
REQ-007 write_req_base  in  1  write data_in_base to the base entry at write_addr_base.
REQ-008 write_addr_base  in  NS_INDEX_ID_BITS  base write index.
REQ-009 data_in_base  in  BASE_STRIDE_WIDTH  base write data.
REQ-010 write_req_stride  in  1  write data_in_stride to the stride entry at write_addr_stride.
REQ-011 write_addr_stride  in  NS_INDEX_ID_BITS  stride write index.
REQ-012 data_in_stride  in  BASE_STRIDE_WIDTH  stride write data.
REQ-013 mem_bypass  in  1  substitute base_plus_stride for the stored base on this read.
REQ-014 base_plus_stride  in  BASE_STRIDE_WIDTH  incremented base from the address generator.
REQ-015 iterator_base  out  BASE_STRIDE_WIDTH  registered base read data.
REQ-016 iterator_stride  out  BASE_STRIDE_WIDTH  registered stride read data.
REQ-017 read_valid  out  1  one-cycle pulse: iterator_base/iterator_stride hold new read data.
REQ-018 init_done  out  1  high once the table has been cleared and accepts traffic.

Function
REQ-019 FSM has two states, INIT and RUN; INIT sweeps a counter 0..DEPTH-1, writing 0 to the base and stride entries at that index, one entry per cycle.
REQ-020 INIT moves to RUN on the cycle after the counter reaches DEPTH-1; init_done is high exactly in RUN.
REQ-021 In INIT, read_req, write_req_base and write_req_stride are ignored, and read_valid stays 0.
REQ-022 In RUN, a write request updates its entry at the clock edge; base and stride writes are independent and may target different indices in the same cycle.
REQ-023 Read latency is 1 cycle: read_req sampled at edge N means iterator_base, iterator_stride and read_valid=1 are valid after edge N.
REQ-024 When there is no read, iterator_base and iterator_stride hold their last values and read_valid is 0.
REQ-025 Read-write collision is write-first: if a write in the same cycle targets read_addr in the same array, the output takes that write's data.
REQ-026 If mem_bypass=1 with read_req=1, iterator_base loads base_plus_stride and ignores both array and forwarded data; iterator_stride is unaffected.
REQ-027 mem_bypass without read_req has no effect.
REQ-028 No arithmetic is performed; all data paths are exactly BASE_STRIDE_WIDTH bits, with no extension or truncation.

Reset
REQ-029 While reset=0: FSM goes to INIT, the sweep counter to 0, iterator_base/iterator_stride to 0, and read_valid/init_done to 0.
REQ-030 Reset asserted mid-operation, in INIT or RUN, aborts everything in flight and restarts the full clear sweep; no write is committed on a reset cycle.
REQ-031 Table contents are defined only by the sweep; no per-entry reset logic is used beyond it.

Structure
REQ-032 FSM state encoding and DEPTH derivation live in the shared genesys package; the parameter defaults match the iterator address generator.
REQ-033 One sub-module, iterator_regfile (1 write port, 1 read port, write-first), is instantiated twice: once for base, once for stride.
REQ-034 One iterator_table instance serves one namespace; the top level instantiates six.

Verification
REQ-035 Reset low for 2 cycles, then high -> init_done rises exactly 32 cycles later; a read of every index returns base=0 and stride=0.
REQ-036 Write base[3]=0x0000_1234 and stride[3]=0xFFFF_FFFC, then read_req addr 3 the next cycle -> 1 cycle later read_valid=1, base=0x0000_1234, stride=0xFFFF_FFFC.
REQ-037 Same cycle: write base[7]=0xA5A5_A5A5 and read_req addr 7 -> output base=0xA5A5_A5A5 (write-first).
REQ-038 read_req addr 3 with mem_bypass=1 and base_plus_stride=0x0000_1230 -> base=0x0000_1230, stride=0xFFFF_FFFC, and table entry 3 is unchanged.
REQ-039 Write base[5]=0x55 during INIT -> ignored; after init_done, a read of entry 5 returns 0.
REQ-040 Reset asserted at RUN cycle 10 after writes -> init_done falls, the sweep reruns for 32 cycles, and all entries read 0 afterwards.
